pc_ctrl: RTL and testbench
==========================

# pc_ctrl

Next-PC controller for the `pc` register. Each cycle it drives the register's `new_pc`, `load` and `pc_load` inputs, choosing between sequential fetch, stall hold, branch, jump, exception entry and exception return. After any redirect it holds a flush window for the pipeline. It also owns the halt state and the EPC/cause registers.

## Interface
- `EXC_VECTOR`, 32'h0000_0080, exception handler address.
- `FLUSH_CYCLES`, 2, flush window length after a redirect (legal range 1..15).
- `CAUSE_W`, 5, width of the exception cause code.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (low = in reset).
- `cur_pc`  in  32  current PC, the `imem_pc` output of the `pc` register.
- `stall`  in  1  hold the PC this cycle.
- `branch_taken`  in  1  redirect to `branch_target`.
- `branch_target`  in  32  branch destination.
- `jump`  in  1  redirect to `jump_target`.
- `jump_target`  in  32  jump destination.
- `exc_req`  in  1  exception request.
- `exc_code`  in  CAUSE_W  exception cause.
- `eret`  in  1  return from exception.
- `halt`  in  1  enter the HALT state.
- `resume`  in  1  leave the HALT state.
- `new_pc`  out  32  to `pc.new_pc`.
- `load`  out  1  to `pc.load`.
- `pc_load`  out  32  to `pc.pc_load`.
- `flush`  out  1  registered; high while in FLUSH.
- `halted`  out  1  registered; high while in HALT.
- `epc`  out  32  saved exception PC.
- `cause`  out  CAUSE_W  saved exception cause.

## Operation
- FSM states: RUN, FLUSH, HALT. A 4-bit counter `fcnt` tracks the flush window.
- `new_pc`, `load` and `pc_load` are combinational from the inputs and the current state.
- `pc_load` always has bits [1:0] forced to 0.
- All arithmetic is 32-bit. `cur_pc + 4` wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- Defaults: `load` = 0, `pc_load` = 0, `new_pc` = `cur_pc + 4`.

RUN (strict priority, highest first):
1. `exc_req`: `load` = 1, `pc_load` = EXC_VECTOR. Registers `epc` ← `cur_pc` and `cause` ← `exc_code`. Next state FLUSH.
2. `eret`: `load` = 1, `pc_load` = `epc`. Next state FLUSH.
3. `jump`: `load` = 1, `pc_load` = `jump_target`. Next state FLUSH.
4. `branch_taken`: `load` = 1, `pc_load` = `branch_target`. Next state FLUSH.
5. `halt`: `new_pc` = `cur_pc`. Next state HALT.
6. `stall`: `new_pc` = `cur_pc`. Stay in RUN.
7. Otherwise: sequential fetch. Stay in RUN.
- Every redirect (items 1-4) loads `fcnt` ← FLUSH_CYCLES.
- A redirect overrides a simultaneous `stall`.

FLUSH:
- `flush` = 1.
- `eret`, `jump`, `branch_taken` and `halt` are ignored; they come from flushed instructions.
- `exc_req` is still honoured with RUN item-1 behaviour. It reloads `fcnt` and stays in FLUSH.
- `stall`: `new_pc` = `cur_pc` and `fcnt` freezes.
- Otherwise fetch is sequential and `fcnt` decrements. When `fcnt` == 1 and there is no stall, next state is RUN.

HALT:
- `halted` = 1 and `new_pc` = `cur_pc`.
- `exc_req` takes the exception (RUN item 1) and clears `halted`.
- Otherwise `resume` returns to RUN.

Reset (`reset` low, asynchronous):
- Registered state: RUN, `fcnt` = 0, `flush` = 0, `halted` = 0, `epc` = 0, `cause` = 0.
- Combinational outputs while in reset: `load` = 0, `pc_load` = 0, `new_pc` = 0.
- Reset in the middle of FLUSH or HALT aborts it immediately, with no pending redirect retained.

## Timing
- Redirect latency: a redirect request in cycle N puts the target on `imem_pc` after edge N.
- `flush` is high for exactly FLUSH_CYCLES unstalled cycles following edge N. Stall cycles extend the window.
- `epc` and `cause` update at the same edge the exception vector loads.
- `eret` in the cycle immediately after an exception is in FLUSH, so it is ignored.
- `halted` rises one edge after `halt` is sampled and falls one edge after `resume` is sampled.
- `resume` sampled outside HALT is ignored.

## Configuration
- `PC_CTRL_EXC_EN` defined: exception entry and `eret` behave as above.
- Undefined: `exc_req`, `exc_code` and `eret` are ignored. `epc` and `cause` are tied to 0, and HALT exits only on `resume`.

## Test plan
- Reset release with `cur_pc` 0 and no requests: `new_pc` sequence 4, 8, 12, with `load` = 0 throughout.
- `branch_taken` with `branch_target` 32'h0000_0103 and `stall` = 1: `load` = 1, `pc_load` = 32'h0000_0100. `flush` is high for 2 cycles, and a jump arriving during FLUSH is ignored.
- `exc_req` at `cur_pc` 32'h0000_0040 with `exc_code` 5: `pc_load` = 32'h80, `epc` = 32'h40, `cause` = 5. A later `eret` (after FLUSH) reloads 32'h40.
- `halt` then 3 idle cycles, then `resume`: `new_pc` = `cur_pc` throughout and `halted` = 1 for 4 cycles. Fetch continues at `cur_pc + 4` after that.
- `cur_pc` 32'hFFFF_FFFC with sequential fetch: `new_pc` = 0.
- `reset` low mid-FLUSH: `flush` = 0 and `new_pc` = 0 immediately. Without `PC_CTRL_EXC_EN`, `exc_req` leaves `load` = 0.

Source files
------------

// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: request/redirect bundle between the pipeline and pc_ctrl.
// master = pipeline side (drives requests), slave = pc_ctrl.
interface pc_ctrl_if #(
  parameter int unsigned CAUSE_W = 5
);
  logic [31:0]        cur_pc;
  logic               stall;
  logic               branch_taken;
  logic [31:0]        branch_target;
  logic               jump;
  logic [31:0]        jump_target;
  logic               exc_req;
  logic [CAUSE_W-1:0] exc_code;
  logic               eret;
  logic               halt;
  logic               resume;
  logic [31:0]        new_pc;
  logic               load;
  logic [31:0]        pc_load;
  logic               flush;
  logic               halted;
  logic [31:0]        epc;
  logic [CAUSE_W-1:0] cause;

  modport master (
    output cur_pc, stall, branch_taken, branch_target,
    output jump, jump_target, exc_req, exc_code,
    output eret, halt, resume,
    input  new_pc, load, pc_load, flush, halted, epc, cause
  );

  modport slave (
    input  cur_pc, stall, branch_taken, branch_target,
    input  jump, jump_target, exc_req, exc_code,
    input  eret, halt, resume,
    output new_pc, load, pc_load, flush, halted, epc, cause
  );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: next-PC controller (RUN / FLUSH / HALT) with EPC/cause.
// Ports: clk, reset (async, active-low), bus (pc_ctrl_if.slave).
//   bus inputs : cur_pc, stall, branch_*, jump*, exc_*, eret, halt, resume
//   bus outputs: new_pc/load/pc_load (comb), flush/halted/epc/cause (reg)
// Option: define PC_CTRL_EXC_EN to enable exception entry and eret.
module pc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CAUSE_W      = 5
) (
  input  logic     clk,
  input  logic     reset,
  pc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_HALT
  } state_t;

  localparam logic [3:0] FCNT_INIT = 4'(FLUSH_CYCLES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_fcnt;
  logic [3:0]  w_fcnt_nxt;
  logic        r_flush;
  logic        r_halted;
  logic        w_exc;
  logic        w_eret;
  logic        w_load;
  logic [31:0] w_target;
  logic [31:0] w_new_pc;
  logic [31:0] w_seq;

  assign w_seq = bus.cur_pc + 32'd4;

`ifdef PC_CTRL_EXC_EN
  logic [31:0]        r_epc;
  logic [CAUSE_W-1:0] r_cause;

  assign w_exc  = bus.exc_req;
  assign w_eret = bus.eret;

  // Exceptions are honoured in every state, so capture on w_exc alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_epc   <= '0;
      r_cause <= '0;
    end else if (w_exc) begin
      r_epc   <= bus.cur_pc;
      r_cause <= bus.exc_code;
    end
  end

  assign bus.epc   = r_epc;
  assign bus.cause = r_cause;
`else
  logic w_unused_exc;

  assign w_unused_exc = ^{bus.exc_req, bus.eret, bus.exc_code};
  assign w_exc        = 1'b0;
  assign w_eret       = 1'b0;
  assign bus.epc      = '0;
  assign bus.cause    = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_load      = 1'b0;
    w_target    = '0;
    w_new_pc    = w_seq;
    unique case (r_state)
      S_RUN: begin
        if (w_exc) begin
          w_load      = 1'b1;
          w_target    = EXC_VECTOR;
          w_fcnt_nxt  = FCNT_INIT;
          w_state_nxt = S_FLUSH;
        end else if (w_eret) begin
          w_load      = 1'b1;
          w_target    = bus.epc;
          w_fcnt_nxt  = FCNT_INIT;
          w_state_nxt = S_FLUSH;
        end else if (bus.jump) begin
          w_load      = 1'b1;
          w_target    = bus.jump_target;
          w_fcnt_nxt  = FCNT_INIT;
          w_state_nxt = S_FLUSH;
        end else if (bus.branch_taken) begin
          w_load      = 1'b1;
          w_target    = bus.branch_target;
          w_fcnt_nxt  = FCNT_INIT;
          w_state_nxt = S_FLUSH;
        end else if (bus.halt) begin
          w_new_pc    = bus.cur_pc;
          w_state_nxt = S_HALT;
        end else if (bus.stall) begin
          w_new_pc    = bus.cur_pc;
        end
      end
      S_FLUSH: begin
        // Only exceptions survive; other requests are from flushed slots.
        if (w_exc) begin
          w_load     = 1'b1;
          w_target   = EXC_VECTOR;
          w_fcnt_nxt = FCNT_INIT;
        end else if (bus.stall) begin
          w_new_pc   = bus.cur_pc;
        end else begin
          w_fcnt_nxt = r_fcnt - 4'd1;
          if (r_fcnt == 4'd1) begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_HALT: begin
        w_new_pc = bus.cur_pc;
        if (w_exc) begin
          w_load      = 1'b1;
          w_target    = EXC_VECTOR;
          w_fcnt_nxt  = FCNT_INIT;
          w_state_nxt = S_FLUSH;
        end else if (bus.resume) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
    if (!reset) begin
      w_load   = 1'b0;
      w_target = '0;
      w_new_pc = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_RUN;
      r_fcnt   <= '0;
      r_flush  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_fcnt   <= w_fcnt_nxt;
      r_flush  <= (w_state_nxt == S_FLUSH);
      r_halted <= (w_state_nxt == S_HALT);
    end
  end

  assign bus.new_pc  = w_new_pc;
  assign bus.load    = w_load;
  assign bus.pc_load = w_target & ~32'h3;
  assign bus.flush   = r_flush;
  assign bus.halted  = r_halted;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: scoreboard bench for pc_ctrl with a behavioural model.
// Driver pushes expectations; monitor pops and compares each cycle.
module tb_pc_ctrl;

  localparam logic [31:0] VEC = 32'h0000_0080;
  localparam int          FC  = 2;
  localparam int          CW  = 5;
`ifdef PC_CTRL_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pc_ctrl_if #(.CAUSE_W(CW)) bus ();

  pc_ctrl #(
    .EXC_VECTOR  (VEC),
    .FLUSH_CYCLES(FC),
    .CAUSE_W     (CW)
  ) u_dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit          rst;
    bit          stall;
    bit          br;
    bit          jmp;
    bit          exc;
    bit          eret;
    bit          halt;
    bit          resume;
    logic [31:0] bt;
    logic [31:0] jt;
    logic [CW-1:0] code;
  } stim_t;

  typedef struct {
    logic [31:0]   new_pc;
    logic          load;
    logic [31:0]   pc_load;
    logic          flush;
    logic          halted;
    logic [31:0]   epc;
    logic [CW-1:0] cause;
    string         tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Model state: PC register contents, remaining unstalled flush
  // cycles, halt flag and saved exception info.
  logic [31:0]   m_pc    = '0;
  logic [31:0]   m_epc   = '0;
  logic [CW-1:0] m_cause = '0;
  int            m_fleft = 0;
  bit            m_halt  = 1'b0;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1; s.stall = 1'b0; s.br = 1'b0; s.jmp = 1'b0;
    s.exc = 1'b0; s.eret = 1'b0; s.halt = 1'b0; s.resume = 1'b0;
    s.bt = '0; s.jt = '0; s.code = '0;
    return s;
  endfunction

  function automatic void chk(string tag, string nm,
                              logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s got=%h want=%h", tag, nm, act, req);
    end
  endfunction

  task automatic model(input stim_t s, input string tag);
    exp_t e;
    logic [31:0] tgt;
    bool_redirect: begin
      bit redir;
      redir = 1'b0;
      tgt   = '0;
      e.tag = tag;
      if (!s.rst) begin
        e.new_pc = '0; e.load = 1'b0; e.pc_load = '0;
        e.flush = 1'b0; e.halted = 1'b0; e.epc = '0; e.cause = '0;
        m_fleft = 0; m_halt = 1'b0; m_epc = '0; m_cause = '0;
        m_pc = '0;
      end else begin
        e.flush  = (m_fleft > 0);
        e.halted = m_halt;
        e.epc    = m_epc;
        e.cause  = m_cause;
        e.load   = 1'b0;
        e.pc_load = '0;
        e.new_pc = m_pc + 32'd4;
        if (m_halt) e.new_pc = m_pc;
        if (EXC_EN && s.exc) begin
          redir = 1'b1; tgt = VEC;
          m_epc = m_pc; m_cause = s.code; m_halt = 1'b0;
        end else if (m_halt) begin
          if (s.resume) m_halt = 1'b0;
        end else if (m_fleft > 0) begin
          if (s.stall) e.new_pc = m_pc;
          else m_fleft--;
        end else if (EXC_EN && s.eret) begin
          redir = 1'b1; tgt = m_epc;
        end else if (s.jmp) begin
          redir = 1'b1; tgt = s.jt;
        end else if (s.br) begin
          redir = 1'b1; tgt = s.bt;
        end else if (s.halt) begin
          e.new_pc = m_pc; m_halt = 1'b1;
        end else if (s.stall) begin
          e.new_pc = m_pc;
        end
        if (redir) begin
          e.load    = 1'b1;
          e.pc_load = {tgt[31:2], 2'b00};
          m_fleft   = FC;
        end
        m_pc = e.load ? e.pc_load : e.new_pc;
      end
    end
    sb.push_back(e);
  endtask

  task automatic step(input stim_t s, input string tag);
    @(negedge clk);
    rst_n             = s.rst;
    bus.cur_pc        = m_pc;
    bus.stall         = s.stall;
    bus.branch_taken  = s.br;
    bus.branch_target = s.bt;
    bus.jump          = s.jmp;
    bus.jump_target   = s.jt;
    bus.exc_req       = s.exc;
    bus.exc_code      = s.code;
    bus.eret          = s.eret;
    bus.halt          = s.halt;
    bus.resume        = s.resume;
    model(s, tag);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.tag, "new_pc", bus.new_pc, e.new_pc);
        chk(e.tag, "load", 32'(bus.load), 32'(e.load));
        chk(e.tag, "pc_load", bus.pc_load, e.pc_load);
        chk(e.tag, "flush", 32'(bus.flush), 32'(e.flush));
        chk(e.tag, "halted", 32'(bus.halted), 32'(e.halted));
        chk(e.tag, "epc", bus.epc, e.epc);
        chk(e.tag, "cause", 32'(bus.cause), 32'(e.cause));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    stim_t s;
    bus.cur_pc = '0; bus.stall = 1'b0; bus.branch_taken = 1'b0;
    bus.branch_target = '0; bus.jump = 1'b0; bus.jump_target = '0;
    bus.exc_req = 1'b0; bus.exc_code = '0; bus.eret = 1'b0;
    bus.halt = 1'b0; bus.resume = 1'b0;

    s = idle(); s.rst = 1'b0;
    step(s, "rst0");
    step(s, "rst1");
    m_pc = '0;
    for (int i = 0; i < 3; i++) step(idle(), "seq");

    m_pc = 32'h0000_0200;
    s = idle(); s.br = 1'b1; s.bt = 32'h0000_0103; s.stall = 1'b1;
    step(s, "br");
    s = idle(); s.jmp = 1'b1; s.jt = 32'h0000_0500;
    step(s, "fl_jmp");
    step(idle(), "fl2");
    step(idle(), "fl_end");

    m_pc = 32'h0000_0040;
    s = idle(); s.exc = 1'b1; s.code = 5'd5;
    step(s, "exc");
    s = idle(); s.eret = 1'b1;
    step(s, "eret_fl");
    step(idle(), "exc_fl");
    step(idle(), "exc_run");
    step(s, "eret");
    step(idle(), "eret_fl");
    step(idle(), "eret_fl2");

    s = idle(); s.halt = 1'b1;
    step(s, "halt");
    for (int i = 0; i < 3; i++) step(idle(), "hidle");
    s = idle(); s.resume = 1'b1;
    step(s, "resume");
    step(idle(), "post_h");
    step(idle(), "post_h2");

    m_pc = 32'hFFFF_FFFC;
    step(idle(), "wrap");
    step(idle(), "wrap2");

    s = idle(); s.br = 1'b1; s.bt = 32'h0000_0300;
    step(s, "br2");
    s = idle(); s.stall = 1'b1;
    step(s, "fl_st");
    step(s, "fl_st2");
    step(idle(), "fl_a");
    step(idle(), "fl_b");

    s = idle(); s.jmp = 1'b1; s.jt = 32'h0000_0600;
    step(s, "jmp3");
    s = idle(); s.rst = 1'b0;
    step(s, "rst_fl");
    s = idle(); s.exc = 1'b1; s.code = 5'd3;
    step(s, "exc2");
    step(idle(), "after");

    for (int i = 0; i < 600; i++) begin
      s = idle();
      s.rst    = ($urandom_range(0, 99) >= 2);
      s.stall  = ($urandom_range(0, 99) < 25);
      s.br     = ($urandom_range(0, 99) < 10);
      s.jmp    = ($urandom_range(0, 99) < 8);
      s.exc    = ($urandom_range(0, 99) < 6);
      s.eret   = ($urandom_range(0, 99) < 8);
      s.halt   = ($urandom_range(0, 99) < 5);
      s.resume = ($urandom_range(0, 99) < 30);
      s.bt     = $urandom;
      s.jt     = $urandom;
      s.code   = CW'($urandom);
      if ($urandom_range(0, 99) < 5) m_pc = {$urandom, 2'b00} >> 2 << 2;
      step(s, "rnd");
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
